// File: rtl/gfx_pkg.sv
// Shared graphics types and constants for the frame-buffer blitter.
package gfx_pkg;

  localparam int SCREEN_W = 240;
  localparam int SCREEN_H = 160;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 24;
  localparam int DIM_W    = 9;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  localparam pixel_t KEY_COLOR = 24'hFF00FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

  function automatic logic is_key(input pixel_t p);
    return (p == KEY_COLOR);
  endfunction

  // y*SCREEN_W + x for signed coordinates, built from shifts (240 = 256 - 16); wraps modulo 2^ADDR_W.
  function automatic fb_addr_t row_origin(input logic signed [10:0] x, input logic signed [10:0] y);
    fb_addr_t xs;
    fb_addr_t ys;
    xs = {{8{x[10]}}, x};
    ys = {{8{y[10]}}, y};
    return (ys << 4'd8) - (ys << 4'd4) + xs;
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Row-major pixel walker: issues one source/destination address pair per clock with
// clip and last-pixel flags, all registered.
module blit_addr_gen
  import gfx_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [DIM_W-1:0]  src_stride,
  input  logic [DIM_W-1:0]  blit_w,
  input  logic [DIM_W-1:0]  blit_h,
  input  logic [9:0]        dst_x,
  input  logic [9:0]        dst_y,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              pix_valid,
  output logic              pix_last,
  output logic              pix_in_bounds
);

  localparam logic signed [10:0] X_LIM = 11'(SCREEN_W);
  localparam logic signed [10:0] Y_LIM = 11'(SCREEN_H);

  logic                    run_r;
  logic [DIM_W-1:0]        col_r;
  logic [DIM_W-1:0]        row_r;
  logic [DIM_W-1:0]        w_last_r;
  logic [DIM_W-1:0]        h_last_r;
  logic [DIM_W-1:0]        stride_r;
  fb_addr_t                src_row_r;
  fb_addr_t                dst_row_r;
  logic signed [10:0]      x0_r;
  logic signed [10:0]      x_r;
  logic signed [10:0]      y_r;

  logic                    row_end_s;
  logic                    last_s;
  logic                    in_bounds_s;
  logic signed [10:0]      dst_x_s;
  logic signed [10:0]      dst_y_s;

  // End-of-row / end-of-blit detection and screen clip test for the current pixel.
  always_comb begin
    dst_x_s     = {dst_x[9], dst_x};
    dst_y_s     = {dst_y[9], dst_y};
    row_end_s   = (col_r == w_last_r);
    last_s      = row_end_s && (row_r == h_last_r);
    in_bounds_s = (x_r >= 11'sd0) && (x_r < X_LIM) && (y_r >= 11'sd0) && (y_r < Y_LIM);
  end

  // Counters and row-base accumulators; the blit parameters are captured on load only.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      run_r         <= 1'b0;
      col_r         <= '0;
      row_r         <= '0;
      w_last_r      <= '0;
      h_last_r      <= '0;
      stride_r      <= '0;
      src_row_r     <= '0;
      dst_row_r     <= '0;
      x0_r          <= '0;
      x_r           <= '0;
      y_r           <= '0;
      src_addr      <= '0;
      dst_addr      <= '0;
      pix_valid     <= 1'b0;
      pix_last      <= 1'b0;
      pix_in_bounds <= 1'b0;
    end else if (load) begin
      run_r         <= 1'b1;
      col_r         <= '0;
      row_r         <= '0;
      w_last_r      <= blit_w - 9'd1;
      h_last_r      <= blit_h - 9'd1;
      stride_r      <= src_stride;
      src_row_r     <= src_base;
      dst_row_r     <= row_origin(dst_x_s, dst_y_s);
      x0_r          <= dst_x_s;
      x_r           <= dst_x_s;
      y_r           <= dst_y_s;
      pix_valid     <= 1'b0;
      pix_last      <= 1'b0;
    end else if (run_r) begin
      src_addr      <= src_row_r + fb_addr_t'(col_r);
      dst_addr      <= dst_row_r + fb_addr_t'(col_r);
      pix_valid     <= 1'b1;
      pix_last      <= last_s;
      pix_in_bounds <= in_bounds_s;
      if (last_s) begin
        run_r <= 1'b0;
      end else if (row_end_s) begin
        col_r     <= '0;
        row_r     <= row_r + 9'd1;
        src_row_r <= src_row_r + fb_addr_t'(stride_r);
        dst_row_r <= dst_row_r + fb_addr_t'(SCREEN_W);
        x_r       <= x0_r;
        y_r       <= y_r + 11'sd1;
      end else begin
        col_r <= col_r + 9'd1;
        x_r   <= x_r + 11'sd1;
      end
    end else begin
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/sprite_blit_writer.sv
// Sprite blitter: copies a WxH rectangle from source RAM into the frame buffer at one pixel per
// clock, skipping key-colour pixels and clipping at the screen edges.
module sprite_blit_writer
  import gfx_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [DIM_W-1:0]  src_stride,
  input  logic [DIM_W-1:0]  blit_w,
  input  logic [DIM_W-1:0]  blit_h,
  input  logic [9:0]        dst_x,
  input  logic [9:0]        dst_y,
  output logic [ADDR_W-1:0] src_read_address,
  input  logic [DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0] fb_write_address,
  output logic [DATA_W-1:0] fb_data_In,
  output logic              fb_we,
  output logic              busy,
  output logic              done
);

  blit_state_t state_r;
  logic        drain_cnt_r;
  logic        dims_ok_s;
  logic        load_s;

  logic        s0_valid_s;
  logic        s0_last_s;
  logic        s0_in_bounds_s;
  fb_addr_t    s0_dst_s;

  logic        s1_valid_r;
  logic        s1_in_bounds_r;
  fb_addr_t    s1_dst_r;

  // Accept a start only from IDLE, and only launch the walker for a non-empty rectangle.
  always_comb begin
    dims_ok_s = (blit_w != 9'd0) && (blit_h != 9'd0);
    load_s    = (state_r == IDLE) && start && dims_ok_s;
  end

  blit_addr_gen u_addr_gen (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .load          (load_s),
    .src_base      (src_base),
    .src_stride    (src_stride),
    .blit_w        (blit_w),
    .blit_h        (blit_h),
    .dst_x         (dst_x),
    .dst_y         (dst_y),
    .src_addr      (src_read_address),
    .dst_addr      (s0_dst_s),
    .pix_valid     (s0_valid_s),
    .pix_last      (s0_last_s),
    .pix_in_bounds (s0_in_bounds_s)
  );

  // Control FSM; busy/done are registered alongside the state so they track it exactly.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      drain_cnt_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start && dims_ok_s) begin
            state_r <= RUN;
            busy    <= 1'b1;
          end else if (start) begin
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // The last pixel's address is now on the bus; two more cycles empty the pipe.
          if (s0_last_s) begin
            state_r     <= DRAIN;
            drain_cnt_r <= 1'b0;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (drain_cnt_r == 1'b1) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_cnt_r <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // S1 waits for the RAM read; S2 commits the write unless clipped or transparent.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_r       <= 1'b0;
      s1_in_bounds_r   <= 1'b0;
      s1_dst_r         <= '0;
      fb_we            <= 1'b0;
      fb_write_address <= '0;
      fb_data_In       <= '0;
    end else begin
      s1_valid_r     <= s0_valid_s;
      s1_in_bounds_r <= s0_in_bounds_s;
      s1_dst_r       <= s0_dst_s;
      if (s1_valid_r && s1_in_bounds_r && !is_key(src_data)) begin
        fb_we            <= 1'b1;
        fb_write_address <= s1_dst_r;
        fb_data_In       <= src_data;
      end else begin
        fb_we <= 1'b0;
      end
    end
  end

endmodule
